// File: rtl/router_out_ctrl_if.sv
// rtl/router_out_ctrl_if.sv - handshake bundle between source FIFO, output controller and destination
//
// Purpose: groups the FIFO-side and destination-side signals of router_out_ctrl.
// Signals:
//   fifo_data  [8:0]  show-ahead FIFO head, bit8 = header marker, [7:0] = byte
//   fifo_empty        FIFO has no entry
//   fifo_rd_en        pop the FIFO head this cycle
//   data_out   [7:0]  output byte to destination
//   vld_out           data_out valid
//   read_enb          destination accepts (transfer = vld_out && read_enb)
//   soft_reset        one-cycle pulse on destination timeout
//   busy_out          controller not idle
//   pkt_done          one-cycle pulse after the parity byte transfers
//   parity_err        parity mismatch flag
// Modports: master = controller view, slave = FIFO/destination view.
interface router_out_ctrl_if;
  logic [8:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] data_out;
  logic       vld_out;
  logic       read_enb;
  logic       soft_reset;
  logic       busy_out;
  logic       pkt_done;
  logic       parity_err;

  modport master (
    input  fifo_data, fifo_empty, read_enb,
    output fifo_rd_en, data_out, vld_out, soft_reset, busy_out, pkt_done, parity_err
  );

  modport slave (
    output fifo_data, fifo_empty, read_enb,
    input  fifo_rd_en, data_out, vld_out, soft_reset, busy_out, pkt_done, parity_err
  );
endinterface

// File: rtl/router_out_ctrl.sv
// rtl/router_out_ctrl.sv - packet output controller draining a show-ahead FIFO to one destination
//
// Purpose: pops header/payload/parity bytes from a show-ahead FIFO into a one-entry
// registered output slot, discards stray bytes between packets, aborts a packet with a
// soft_reset pulse when the destination stalls for TIMEOUT cycles and flushes the rest
// of that packet from the FIFO.
// Parameters:
//   TIMEOUT  consecutive stalled cycles before soft reset (2..63)
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-low reset
//   bus  router_out_ctrl_if.master (FIFO head/pop, output byte/valid, destination accept,
//        soft_reset, busy_out, pkt_done, parity_err)
// Optional feature: define ROUTER_OUT_PARITY_CHK_EN to enable the running-XOR parity check;
// otherwise parity_err is tied low.
module router_out_ctrl #(
  parameter int TIMEOUT = 30
) (
  input logic             clk,
  input logic             rst,
  router_out_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam logic [5:0] STALL_MAX = 6'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [5:0] stall_q;
  logic [7:0] data_q;
  logic       vld_q;
  logic       last_q;
  logic       soft_q;
  logic       done_q;

  logic       xfer;
  logic       slot_free;
  logic       head_hdr;
  logic       timeout;
  logic       pop;
  logic       load;
  logic       load_last;

  assign xfer      = vld_q & bus.read_enb;
  // The slot can take a new byte in the same cycle its current byte leaves.
  assign slot_free = ~vld_q | bus.read_enb;
  assign head_hdr  = bus.fifo_data[8];
  // A transfer in the final allowed cycle beats the timeout.
  assign timeout   = vld_q & ~bus.read_enb & (stall_q == STALL_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pop       = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    if (timeout) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE: begin
          if (slot_free && !bus.fifo_empty) begin
            pop = 1'b1;
            if (head_hdr) begin
              load    = 1'b1;
              len_d   = bus.fifo_data[7:2];
              state_d = (bus.fifo_data[7:2] == 6'd0) ? PARITY : PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (slot_free && !bus.fifo_empty) begin
            pop   = 1'b1;
            load  = 1'b1;
            len_d = len_q - 6'd1;
            if (len_q == 6'd1) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (slot_free && !bus.fifo_empty) begin
            pop       = 1'b1;
            load      = 1'b1;
            load_last = 1'b1;
            state_d   = IDLE;
          end
        end
        FLUSH: begin
          // Drain the aborted packet's remaining bytes; stop at the next header.
          if (bus.fifo_empty || head_hdr) begin
            state_d = IDLE;
          end else if (slot_free) begin
            pop = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      stall_q <= 6'd0;
      soft_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (timeout) begin
        // Abort: drop the stalled byte and forget that it was a parity byte.
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end else if (load) begin
        data_q <= bus.fifo_data[7:0];
        vld_q  <= 1'b1;
        last_q <= load_last;
      end else if (xfer) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end

      if (vld_q && !bus.read_enb && !timeout) begin
        stall_q <= stall_q + 6'd1;
      end else begin
        stall_q <= 6'd0;
      end

      soft_q <= timeout;
      done_q <= xfer & last_q;
    end
  end

`ifdef ROUTER_OUT_PARITY_CHK_EN
  logic [7:0] acc_q;
  logic       perr_q;
  logic       hdr_pop;

  assign hdr_pop = pop & head_hdr & (state_q == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= 8'h00;
      perr_q <= 1'b0;
    end else if (hdr_pop) begin
      // The header byte itself seeds the running XOR.
      acc_q  <= bus.fifo_data[7:0];
      perr_q <= 1'b0;
    end else if (load_last) begin
      perr_q <= (acc_q != bus.fifo_data[7:0]);
    end else if (load) begin
      acc_q  <= acc_q ^ bus.fifo_data[7:0];
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.fifo_rd_en = pop & rst;
  assign bus.data_out   = data_q;
  assign bus.vld_out    = vld_q;
  assign bus.soft_reset = soft_q;
  assign bus.busy_out   = (state_q != IDLE);
  assign bus.pkt_done   = done_q;

endmodule

// File: doc/router_out_ctrl.md
ROUTER_OUT_CTRL -- requirements
Module: router_out_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 30: consecutive stalled cycles before soft reset, range 2..63.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 fifo_data  in  9  show-ahead FIFO head; bit8 = header marker, [7:0] = byte; valid while fifo_empty=0.
REQ-005 fifo_empty  in  1  FIFO has no entry.
REQ-006 fifo_rd_en  out  1  pop FIFO head this cycle; combinational.
REQ-007 data_out  out  8  registered output byte.
REQ-008 vld_out  out  1  data_out valid to destination.
REQ-009 read_enb  in  1  destination accept; transfer = vld_out && read_enb.
REQ-010 soft_reset  out  1  one-cycle pulse on destination timeout.
REQ-011 busy_out  out  1  high in any state other than IDLE.
REQ-012 pkt_done  out  1  one-cycle pulse when parity byte transfers.
REQ-013 parity_err  out  1  parity mismatch flag (see Configuration).

Function
REQ-014 States: IDLE, PAYLOAD, PARITY, FLUSH; encoded in a registered state variable.
REQ-015 Output slot free when vld_out=0 or transfer this cycle; pops occur only when slot free, fifo_empty=0, and not FLUSH-blocked.
REQ-016 Popped byte appears on data_out with vld_out=1 the next cycle (latency 1); data_out/vld_out hold until transfer.
REQ-017 IDLE, head has bit8=1: pop, load length counter with fifo_data[7:2], go PAYLOAD (length 0 -> PARITY).
REQ-018 IDLE, head has bit8=0: pop and discard (vld_out not set), stay IDLE.
REQ-019 PAYLOAD: each pop decrements counter; pop with counter=1 -> PARITY.
REQ-020 PARITY: pop marks slot as last byte, go IDLE.
REQ-021 pkt_done pulses in the cycle after the last-marked byte transfers.
REQ-022 Stall counter (6 bits) increments each cycle vld_out=1 and read_enb=0; clears on transfer or vld_out=0.
REQ-023 Counter reaching TIMEOUT-1 with read_enb=0: next cycle soft_reset=1, vld_out=0, counter=0, state FLUSH.
REQ-024 read_enb=1 in the cycle the counter reaches TIMEOUT-1: transfer wins, no soft_reset.
REQ-025 FLUSH: pop every head with bit8=0; head with bit8=1 or fifo_empty=1 -> IDLE without popping.
REQ-026 pkt_done never pulses for a packet aborted by timeout.
REQ-027 fifo_empty=1 in PAYLOAD/PARITY: no pop, state held, stall counter unaffected unless vld_out=1.

Reset
REQ-028 rst=0 asynchronously forces: state IDLE, counters 0, data_out=8'h00, vld_out=0, soft_reset=0, pkt_done=0, parity_err=0, last flag 0.
REQ-029 Reset mid-packet abandons the packet; no pkt_done, no pops until rst=1.
REQ-030 fifo_rd_en=0 while rst=0.

Configuration
REQ-031 Macro ROUTER_OUT_PARITY_CHK_EN defined: running XOR over header and payload bytes, cleared at header pop; parity byte pop compares; mismatch sets parity_err next cycle, held until next header pop.
REQ-032 Macro undefined: XOR logic absent, parity_err tied 0; all other behaviour identical.

Verification
REQ-033 FIFO {1_0C, 0_11, 0_22, 0_33, 0_0C}, read_enb=1 -> data_out 0C,11,22,33,0C on consecutive cycles, pkt_done one pulse, parity_err=0.
REQ-034 Same packet with parity byte 0x0D, macro defined -> parity_err=1 after parity pop; cleared at next header pop; undefined -> parity_err=0.
REQ-035 Header 0x0C, read_enb=0 throughout -> vld_out held 30 cycles, soft_reset pulse once, remaining 0_xx bytes flushed, next 1_xx header left in FIFO, state IDLE.
REQ-036 read_enb rises on 30th stalled cycle -> transfer completes, soft_reset stays 0.
REQ-037 Header 0x00 then parity 0x00 -> two bytes out, pkt_done pulse; stray 0_55 in IDLE popped without vld_out.
REQ-038 rst low while PAYLOAD mid-packet -> all outputs at reset values same cycle (async), no pkt_done.
